mem_initiator: RTL and testbench
================================

# mem_initiator

Request-side master for the memory-peripheral bus. It accepts one load/store command at a time from the core over a valid/ready handshake and drives one bus request cycle with `o_req_addr`/`o_req_count`. It waits a fixed response latency, then samples the responder's `i_res_code`/`i_res_rd_data` and returns a single-cycle result to the core. Load data is returned sign- or zero-extended. It sits between the load/store stage and the peripheral decode (readonly/readwrite register banks, RAM).

## Interface
Parameters:
- `RES_LATENCY`, 1: cycles from the bus request cycle to a valid response (≥1).

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: reset, synchronous, active-low.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: command accepted when high with `i_cmd_valid`.
- `i_cmd_write` in 1: 1 = store, 0 = load.
- `i_cmd_count` in `MEM_COUNT_W`: `MEM_COUNT_NONE/BYTE/HALF/WORD`.
- `i_cmd_signed` in 1: sign-extend load result.
- `i_cmd_addr` in `ADDR_W`: byte address.
- `i_cmd_wr_data` in `WORD_W`: store data, low-justified.
- `o_req_addr` out `ADDR_W`: bus address.
- `o_req_count` out `MEM_COUNT_W`: bus size; `MEM_COUNT_NONE` = idle.
- `o_req_wr_en` out 1: bus write.
- `o_req_wr_data` out `WORD_W`: bus write data, low-justified, unshifted.
- `i_res_rd_data` in `WORD_W`: responder data, low-justified.
- `i_res_code` in `MEM_CODE_W`: responder code.
- `o_rsp_valid` out 1: one-cycle result pulse.
- `o_rsp_data` out `WORD_W`: extended load data; 0 for stores and errors.
- `o_rsp_code` out `MEM_CODE_W`: final code.
- `o_rsp_err` out 1: code is not the expected success code.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**: `o_cmd_ready`=1. On `i_cmd_valid`, latch the command.
  - `i_cmd_count`==NONE → RESP with `MEM_CODE_INVALID`, err=1.
  - Otherwise → REQ.
- **REQ**: for exactly one cycle drive `o_req_count`/`addr`/`wr_en`/`wr_data` from the latched command. Load the latency counter with `RES_LATENCY-1`, then go to WAIT. In every other state `o_req_count`=NONE and `o_req_wr_en`=0; addr/data hold their last value.
- **WAIT**: decrement the counter. At 0, sample `i_res_code`/`i_res_rd_data` and go to RESP.
- **RESP**: `o_rsp_valid`=1 for one cycle, then IDLE.
- Expected success code: `MEM_CODE_READ` for loads, `MEM_CODE_WRITE` for stores.
  - Any other sampled code is passed through with err=1 and data=0, including the opposite success code (err=1, code unchanged).
- Load extension on success:
  - BYTE: bits [7:0], extended from bit 7 when signed.
  - HALF: bits [15:0], extended from bit 15 when signed.
  - WORD: unchanged.
  - Upper responder bits are ignored.
- Reset, asserted low at any edge, including mid-transaction: state=IDLE, `o_cmd_ready`=0 during reset, `o_req_count`=NONE, `o_req_wr_en`=0, `o_req_addr`/`o_req_wr_data`=0, `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_code`=`MEM_CODE_INVALID`, `o_rsp_err`=0. An abandoned request produces no response.

## Timing
- Accept at edge T (valid & ready). Bus request is visible in cycle T+1. The response is sampled at the end of cycle T+1+`RES_LATENCY`. `o_rsp_valid` is high in cycle T+2+`RES_LATENCY`; with default latency, 3 cycles after accept.
- `o_cmd_ready` is low from T+1 until the cycle after the RESP pulse. Maximum throughput is one command per `RES_LATENCY`+3 cycles.
- Early-reject paths (NONE, precheck misalign) have `o_rsp_valid` at T+1 with no bus cycle.
- All outputs are registered.

## Configuration
- `MEM_INITIATOR_PRECHECK_EN` defined: in IDLE, HALF with `addr[0]`≠0 or WORD with `addr[1:0]`≠0 goes straight to RESP with `MEM_CODE_MISALIGNED`, err=1, and no bus request.
- Not defined: misaligned commands are issued on the bus, and the responder's code is reported.

## Structure
- `MEM_COUNT_*`, `MEM_CODE_*` (including `MEM_CODE_WRITE`), `WORD_W`, `ADDR_W`, `MEM_COUNT_W`, `MEM_CODE_W` come from the shared `config.vh`/`mem_codes.vh` headers. FSM state encodings are local.
- One sub-module, `load_extend`: combinational count/signed → extended word, reusable by the core's load path.

## Test plan
- Signed BYTE load of 0x100, responder returns data 0x00000080 code READ → rsp_data 0xFFFFFF80, err=0, `o_rsp_valid` 3 cycles after accept.
- Unsigned HALF load, responder returns 0xFFFF8001 → rsp_data 0x00008001.
- WORD store of 0xDEADBEEF to 0x8 → one bus cycle with count WORD, wr_en=1, wr_data 0xDEADBEEF. Responder returns READ → err=1, code READ.
- WORD load to 0x102 with precheck on → no bus cycle, rsp MISALIGNED at T+1. With precheck off → bus cycle issued and the responder's MISALIGNED is passed through.
- `RES_LATENCY`=3 → `o_rsp_valid` at T+5. Reset asserted in WAIT → outputs return to reset values next edge, no `o_rsp_valid`, ready after release.
- Command with count NONE → immediate INVALID, err=1, `o_req_count` stays NONE.

Source files
------------

// File: rtl/mem_initiator_pkg.sv
// rtl/mem_initiator_pkg.sv - shared widths, bus size/response codes and command helpers
package mem_initiator_pkg;

  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READONLY   = 3'd4;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NOT_FOUND  = 3'd5;

  // Only the parts of a command that matter after the bus cycle has been issued
  typedef struct packed {
    logic                   write;
    logic [MEM_COUNT_W-1:0] count;
    logic                   sgn;
  } mem_cmd_t;

  // Success code a responder is expected to return for this access direction
  function automatic logic [MEM_CODE_W-1:0] expected_code(input logic write);
    return write ? MEM_CODE_WRITE : MEM_CODE_READ;
  endfunction

  // HALF needs 2-byte alignment, WORD needs 4-byte alignment
  function automatic logic is_misaligned(input logic [MEM_COUNT_W-1:0] count,
                                         input logic [1:0]             addr_lsb);
    logic mis;
    mis = 1'b0;
    if (count == MEM_COUNT_HALF) mis = addr_lsb[0];
    if (count == MEM_COUNT_WORD) mis = |addr_lsb;
    return mis;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - command, bus request/response and result signals of mem_initiator
interface mem_initiator_if;
  import mem_initiator_pkg::*;

  // core command
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic                   i_cmd_write;
  logic [MEM_COUNT_W-1:0] i_cmd_count;
  logic                   i_cmd_signed;
  logic [ADDR_W-1:0]      i_cmd_addr;
  logic [WORD_W-1:0]      i_cmd_wr_data;

  // bus request
  logic [ADDR_W-1:0]      o_req_addr;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic                   o_req_wr_en;
  logic [WORD_W-1:0]      o_req_wr_data;

  // bus response
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  // result to core
  logic                   o_rsp_valid;
  logic [WORD_W-1:0]      o_rsp_data;
  logic [MEM_CODE_W-1:0]  o_rsp_code;
  logic                   o_rsp_err;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_count, i_cmd_signed, i_cmd_addr, i_cmd_wr_data,
    input  i_res_rd_data, i_res_code,
    output o_cmd_ready,
    output o_req_addr, o_req_count, o_req_wr_en, o_req_wr_data,
    output o_rsp_valid, o_rsp_data, o_rsp_code, o_rsp_err
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_count, i_cmd_signed, i_cmd_addr, i_cmd_wr_data,
    output i_res_rd_data, i_res_code,
    input  o_cmd_ready,
    input  o_req_addr, o_req_count, o_req_wr_en, o_req_wr_data,
    input  o_rsp_valid, o_rsp_data, o_rsp_code, o_rsp_err
  );

endinterface

// File: rtl/mem_initiator_load_extend.sv
// rtl/mem_initiator_load_extend.sv - load_extend: size/sign extension of low-justified load data
module load_extend
  import mem_initiator_pkg::*;
(
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic                   sgn,
  input  logic [WORD_W-1:0]      data,
  output logic [WORD_W-1:0]      ext
);

  // Keep only the accessed low bytes; upper responder bits are ignored
  always_comb begin
    ext = data;
    case (count)
      MEM_COUNT_BYTE: ext = {{(WORD_W-8){sgn & data[7]}}, data[7:0]};
      MEM_COUNT_HALF: ext = {{(WORD_W-16){sgn & data[15]}}, data[15:0]};
      default:        ext = data;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - load/store bus request master; MEM_INITIATOR_PRECHECK_EN enables alignment precheck
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int RES_LATENCY = 1
)
(
  input  logic            clk,
  input  logic            aresetn,
  mem_initiator_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int CNT_W = (RES_LATENCY > 1) ? $clog2(RES_LATENCY) : 1;

  state_t            state;
  mem_cmd_t          cmd;
  logic [CNT_W-1:0]  lat_cnt;
  logic [WORD_W-1:0] ext_data;

  load_extend u_load_extend (
    .count (cmd.count),
    .sgn   (cmd.sgn),
    .data  (bus.i_res_rd_data),
    .ext   (ext_data)
  );

  // Command FSM: accept, one bus request cycle, fixed-latency wait, one-cycle result
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      cmd               <= '0;
      lat_cnt           <= '0;
      bus.o_cmd_ready   <= 1'b0;
      bus.o_req_addr    <= '0;
      bus.o_req_count   <= MEM_COUNT_NONE;
      bus.o_req_wr_en   <= 1'b0;
      bus.o_req_wr_data <= '0;
      bus.o_rsp_valid   <= 1'b0;
      bus.o_rsp_data    <= '0;
      bus.o_rsp_code    <= MEM_CODE_INVALID;
      bus.o_rsp_err     <= 1'b0;
    end else begin
      // request and result strobes are single-cycle unless a state re-asserts them
      bus.o_req_count <= MEM_COUNT_NONE;
      bus.o_req_wr_en <= 1'b0;
      bus.o_rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          bus.o_cmd_ready <= 1'b1;
          if (bus.o_cmd_ready && bus.i_cmd_valid) begin
            bus.o_cmd_ready <= 1'b0;
            cmd <= '{write: bus.i_cmd_write, count: bus.i_cmd_count, sgn: bus.i_cmd_signed};
            if (bus.i_cmd_count == MEM_COUNT_NONE) begin
              state           <= ST_RESP;
              bus.o_rsp_valid <= 1'b1;
              bus.o_rsp_data  <= '0;
              bus.o_rsp_code  <= MEM_CODE_INVALID;
              bus.o_rsp_err   <= 1'b1;
            end
`ifdef MEM_INITIATOR_PRECHECK_EN
            else if (is_misaligned(bus.i_cmd_count, bus.i_cmd_addr[1:0])) begin
              state           <= ST_RESP;
              bus.o_rsp_valid <= 1'b1;
              bus.o_rsp_data  <= '0;
              bus.o_rsp_code  <= MEM_CODE_MISALIGNED;
              bus.o_rsp_err   <= 1'b1;
            end
`endif
            else begin
              // registered so the bus sees the request exactly in the REQ cycle
              state             <= ST_REQ;
              bus.o_req_addr    <= bus.i_cmd_addr;
              bus.o_req_count   <= bus.i_cmd_count;
              bus.o_req_wr_en   <= bus.i_cmd_write;
              bus.o_req_wr_data <= bus.i_cmd_wr_data;
            end
          end
        end

        ST_REQ: begin
          lat_cnt <= CNT_W'(RES_LATENCY - 1);
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state           <= ST_RESP;
            bus.o_rsp_valid <= 1'b1;
            bus.o_rsp_code  <= bus.i_res_code;
            if (bus.i_res_code == expected_code(cmd.write)) begin
              bus.o_rsp_data <= cmd.write ? '0 : ext_data;
              bus.o_rsp_err  <= 1'b0;
            end else begin
              bus.o_rsp_data <= '0;
              bus.o_rsp_err  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          bus.o_cmd_ready <= 1'b1;
          state           <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - randomized self-checking bench for mem_initiator at latencies 1 and 3
module tb_mem_initiator;
  import mem_initiator_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  mem_initiator_if bus1 ();
  mem_initiator_if bus3 ();

  mem_initiator #(.RES_LATENCY(1)) u_dut1 (.clk(clk), .aresetn(aresetn), .bus(bus1));
  mem_initiator #(.RES_LATENCY(3)) u_dut3 (.clk(clk), .aresetn(aresetn), .bus(bus3));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic [1:0]  req_count;
    logic [31:0] req_addr;
    logic        req_wr_en;
    logic [31:0] req_wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_code;
    logic        rsp_err;
  } obs_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input int d);
    obs_t o;
    if (d == 0) begin
      o = '{bus1.o_cmd_ready, bus1.o_req_count, bus1.o_req_addr, bus1.o_req_wr_en, bus1.o_req_wr_data,
            bus1.o_rsp_valid, bus1.o_rsp_data, bus1.o_rsp_code, bus1.o_rsp_err};
    end else begin
      o = '{bus3.o_cmd_ready, bus3.o_req_count, bus3.o_req_addr, bus3.o_req_wr_en, bus3.o_req_wr_data,
            bus3.o_rsp_valid, bus3.o_rsp_data, bus3.o_rsp_code, bus3.o_rsp_err};
    end
    return o;
  endfunction

  task automatic drive_cmd(input logic v, input logic w, input logic [1:0] cnt, input logic s,
                           input logic [31:0] a, input logic [31:0] wd);
    bus1.i_cmd_valid = v; bus1.i_cmd_write = w; bus1.i_cmd_count = cnt;
    bus1.i_cmd_signed = s; bus1.i_cmd_addr = a; bus1.i_cmd_wr_data = wd;
    bus3.i_cmd_valid = v; bus3.i_cmd_write = w; bus3.i_cmd_count = cnt;
    bus3.i_cmd_signed = s; bus3.i_cmd_addr = a; bus3.i_cmd_wr_data = wd;
  endtask

  task automatic drive_res(input logic [31:0] rd, input logic [2:0] code);
    bus1.i_res_rd_data = rd; bus1.i_res_code = code;
    bus3.i_res_rd_data = rd; bus3.i_res_code = code;
  endtask

  task automatic check_reset(input string name);
    for (int d = 0; d < 2; d++) begin
      obs_t o;
      o = snap(d);
      chk($sformatf("%s_d%0d_ready", name, d), 32'(o.ready), 32'd0);
      chk($sformatf("%s_d%0d_req_count", name, d), 32'(o.req_count), 32'(MEM_COUNT_NONE));
      chk($sformatf("%s_d%0d_req_wr_en", name, d), 32'(o.req_wr_en), 32'd0);
      chk($sformatf("%s_d%0d_req_addr", name, d), o.req_addr, 32'd0);
      chk($sformatf("%s_d%0d_req_wr_data", name, d), o.req_wr_data, 32'd0);
      chk($sformatf("%s_d%0d_rsp_valid", name, d), 32'(o.rsp_valid), 32'd0);
      chk($sformatf("%s_d%0d_rsp_data", name, d), o.rsp_data, 32'd0);
      chk($sformatf("%s_d%0d_rsp_code", name, d), 32'(o.rsp_code), 32'(MEM_CODE_INVALID));
      chk($sformatf("%s_d%0d_rsp_err", name, d), 32'(o.rsp_err), 32'd0);
    end
  endtask

  // Reference: extended load value by arithmetic on the numeric value of the accessed bytes
  function automatic logic [31:0] model_load(input logic [1:0] cnt, input logic s, input logic [31:0] rd);
    longint v;
    if (cnt == MEM_COUNT_BYTE) begin
      v = longint'(rd) % 256;
      if (s && v >= 128) v = v - 256;
    end else if (cnt == MEM_COUNT_HALF) begin
      v = longint'(rd) % 65536;
      if (s && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  function automatic bit model_early_misaligned(input logic [1:0] cnt, input logic [31:0] a);
`ifdef MEM_INITIATOR_PRECHECK_EN
    return (cnt == MEM_COUNT_HALF && (a % 2) != 0) || (cnt == MEM_COUNT_WORD && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One transaction on both DUTs at once; responder inputs are held for the whole transaction
  task automatic run_txn(input string name, input logic w, input logic [1:0] cnt, input logic s,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [2:0] code);
    int guard;
    bit early, ok;
    logic [31:0] exp_data;
    logic [2:0] exp_code;
    int n_req[2], req_cyc[2], n_rsp[2], rsp_cyc[2], ready_bad[2];
    obs_t req_o[2], rsp_o[2];

    early    = (cnt == MEM_COUNT_NONE) || model_early_misaligned(cnt, a);
    exp_code = (cnt == MEM_COUNT_NONE) ? MEM_CODE_INVALID :
               early ? MEM_CODE_MISALIGNED : code;
    ok       = !early && (code == (w ? MEM_CODE_WRITE : MEM_CODE_READ));
    exp_data = (ok && !w) ? model_load(cnt, s, rd) : 32'd0;

    guard = 0;
    while (!(bus1.o_cmd_ready && bus3.o_cmd_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_idle_ready"}, 32'(bus1.o_cmd_ready && bus3.o_cmd_ready), 32'd1);

    for (int d = 0; d < 2; d++) begin
      n_req[d] = 0; req_cyc[d] = -1; n_rsp[d] = 0; rsp_cyc[d] = -1; ready_bad[d] = 0;
      req_o[d] = snap(d); rsp_o[d] = snap(d);
    end

    drive_cmd(1'b1, w, cnt, s, a, wd);
    drive_res(rd, code);
    @(posedge clk);
    #1;
    drive_cmd(1'b0, w, cnt, s, a, wd);

    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        obs_t o;
        int rsp_at;
        o = snap(d);
        rsp_at = early ? 1 : (2 + ((d == 0) ? 1 : 3));
        if (o.req_count != MEM_COUNT_NONE || o.req_wr_en) begin
          n_req[d]++; req_cyc[d] = c; req_o[d] = o;
        end
        if (o.rsp_valid) begin
          n_rsp[d]++; rsp_cyc[d] = c; rsp_o[d] = o;
        end
        if (c <= rsp_at && o.ready) ready_bad[d]++;
        if (c == rsp_at + 1 && !o.ready) ready_bad[d]++;
      end
    end

    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = (d == 0) ? 1 : 3;
      chk($sformatf("%s_d%0d_rsp_pulses", name, d), 32'(n_rsp[d]), 32'd1);
      chk($sformatf("%s_d%0d_rsp_cycle", name, d), 32'(rsp_cyc[d]), early ? 32'd1 : 32'(2 + lat));
      chk($sformatf("%s_d%0d_rsp_data", name, d), rsp_o[d].rsp_data, exp_data);
      chk($sformatf("%s_d%0d_rsp_code", name, d), 32'(rsp_o[d].rsp_code), 32'(exp_code));
      chk($sformatf("%s_d%0d_rsp_err", name, d), 32'(rsp_o[d].rsp_err), 32'(!ok));
      chk($sformatf("%s_d%0d_ready_timing", name, d), 32'(ready_bad[d]), 32'd0);
      chk($sformatf("%s_d%0d_req_cycles", name, d), 32'(n_req[d]), early ? 32'd0 : 32'd1);
      if (!early) begin
        chk($sformatf("%s_d%0d_req_cycle", name, d), 32'(req_cyc[d]), 32'd1);
        chk($sformatf("%s_d%0d_req_addr", name, d), req_o[d].req_addr, a);
        chk($sformatf("%s_d%0d_req_count", name, d), 32'(req_o[d].req_count), 32'(cnt));
        chk($sformatf("%s_d%0d_req_wr_en", name, d), 32'(req_o[d].req_wr_en), 32'(w));
        chk($sformatf("%s_d%0d_req_wr_data", name, d), req_o[d].req_wr_data, wd);
      end
    end
  endtask

  initial begin
    int pulses;
    drive_cmd(1'b0, 1'b0, MEM_COUNT_NONE, 1'b0, 32'd0, 32'd0);
    drive_res(32'd0, MEM_CODE_INVALID);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    aresetn = 1'b1;

    run_txn("byte_signed", 1'b0, MEM_COUNT_BYTE, 1'b1, 32'h100, 32'h0, 32'h0000_0080, MEM_CODE_READ);
    run_txn("half_unsigned", 1'b0, MEM_COUNT_HALF, 1'b0, 32'h204, 32'h0, 32'hFFFF_8001, MEM_CODE_READ);
    run_txn("half_signed", 1'b0, MEM_COUNT_HALF, 1'b1, 32'h206, 32'h0, 32'h1234_8001, MEM_CODE_READ);
    run_txn("store_wrong_code", 1'b1, MEM_COUNT_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h5555_5555, MEM_CODE_READ);
    run_txn("store_ok", 1'b1, MEM_COUNT_WORD, 1'b0, 32'hC, 32'hCAFE_F00D, 32'h5555_5555, MEM_CODE_WRITE);
    run_txn("word_misaligned", 1'b0, MEM_COUNT_WORD, 1'b0, 32'h102, 32'h0, 32'h7777_7777, MEM_CODE_MISALIGNED);
    run_txn("count_none", 1'b0, MEM_COUNT_NONE, 1'b0, 32'h40, 32'h0, 32'h1111_1111, MEM_CODE_READ);
    run_txn("word_load", 1'b0, MEM_COUNT_WORD, 1'b1, 32'h10, 32'h0, 32'h8765_4321, MEM_CODE_READ);

    for (int i = 0; i < 30; i++) begin
      logic w, s;
      logic [1:0] cnt;
      logic [2:0] code;
      logic [31:0] a, wd, rd;
      w   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      cnt = 2'($urandom_range(0, 3));
      a   = $urandom & 32'h0000_0FFF;
      wd  = $urandom;
      rd  = $urandom;
      if ($urandom_range(0, 3) < 2) code = w ? MEM_CODE_WRITE : MEM_CODE_READ;
      else code = 3'($urandom_range(0, 5));
      run_txn($sformatf("rand%0d", i), w, cnt, s, a, wd, rd, code);
    end

    // Reset while both DUTs are in their wait phase: the request is abandoned
    drive_cmd(1'b1, 1'b0, MEM_COUNT_WORD, 1'b0, 32'h200, 32'h0);
    drive_res(32'h1234_5678, MEM_CODE_READ);
    @(posedge clk);
    #1;
    drive_cmd(1'b0, 1'b0, MEM_COUNT_WORD, 1'b0, 32'h200, 32'h0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    @(negedge clk);
    aresetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus1.o_rsp_valid) pulses++;
      if (bus3.o_rsp_valid) pulses++;
    end
    chk("mid_reset_no_rsp", 32'(pulses), 32'd0);
    chk("mid_reset_ready1", 32'(bus1.o_cmd_ready), 32'd1);
    chk("mid_reset_ready3", 32'(bus3.o_cmd_ready), 32'd1);

    run_txn("after_reset", 1'b0, MEM_COUNT_BYTE, 1'b0, 32'h301, 32'h0, 32'hABCD_EFF0, MEM_CODE_READ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
